// File: rtl/riio_bias_ctrl.sv
// Bias macro power sequencer: bandgap startup kick, settle wait with bounded retry,
// fault latch, and READY-gated channel/VBIAS enables with loadable trim registers.
module riio_bias_ctrl #(
  parameter int N_CH        = 16,
  parameter int STARTUP_CYC = 8,
  parameter int SETTLE_CYC  = 64,
  parameter int MAX_RETRY   = 3
) (
  input  logic            CLK_I,
  input  logic            RST_N_I,
  input  logic            EN_I,
  input  logic            EN_VBIAS_I,
  input  logic [N_CH-1:0] CH_EN_I,
  input  logic            TRIM_LD_I,
  input  logic [3:0]      TRIM_BIAS_I,
  input  logic [4:0]      TRIM_CURV_I,
  input  logic [4:0]      TRIM_VBG_I,
  input  logic            BG_VALID_N_I,
  output logic            BG_EN_O,
  output logic            BG_STARTUP_O,
  output logic            VBIAS_EN_O,
  output logic [3:0]      TRIM_BIAS_O,
  output logic [4:0]      TRIM_CURV_O,
  output logic [4:0]      TRIM_VBG_O,
  output logic [N_CH-1:0] CH_EN_O,
  output logic            READY_O,
  output logic            FAULT_O,
  output logic [2:0]      STATE_O
);

  localparam int CNT_MAX = (STARTUP_CYC > SETTLE_CYC) ? STARTUP_CYC : SETTLE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] START_LOAD  = CNT_W'(STARTUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [2:0]       RETRY_LIM   = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    STARTUP = 3'd1,
    SETTLE  = 3'd2,
    READY   = 3'd3,
    FAULT   = 3'd4
  } stateT;

  stateT            state, nextState;
  logic [CNT_W-1:0] cycleCnt, nextCnt;
  logic [2:0]       retryCnt, nextRetry;
  logic             lowSeen, nextLow;
  logic             validSync1, validSync2;
  logic             bgValid;
  logic             doRetry;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      validSync1 <= 1'b1;
      validSync2 <= 1'b1;
    end else begin
      validSync1 <= BG_VALID_N_I;
      validSync2 <= validSync1;
    end
  end

  assign bgValid = !validSync2;

  // Failed settle and a sustained READY drop share one retry/fault decision.
  always_comb begin
    nextState = state;
    nextCnt   = cycleCnt;
    nextRetry = retryCnt;
    nextLow   = 1'b0;
    doRetry   = 1'b0;
    if (!EN_I) begin
      nextState = OFF;
      nextCnt   = '0;
      nextRetry = '0;
    end else begin
      case (state)
        OFF: begin
          nextState = STARTUP;
          nextCnt   = START_LOAD;
        end
        STARTUP: begin
          if (cycleCnt == '0) begin
            nextState = SETTLE;
            nextCnt   = SETTLE_LOAD;
          end else begin
            nextCnt = cycleCnt - CNT_W'(1);
          end
        end
        SETTLE: begin
          if (bgValid) begin
            nextState = READY;
            nextCnt   = '0;
          end else if (cycleCnt == '0) begin
            doRetry = 1'b1;
          end else begin
            nextCnt = cycleCnt - CNT_W'(1);
          end
        end
        READY: begin
          if (!bgValid && lowSeen) begin
            doRetry = 1'b1;
          end else if (TRIM_LD_I) begin
            nextState = SETTLE;
            nextCnt   = SETTLE_LOAD;
          end else begin
            nextLow = !bgValid;
          end
        end
        FAULT: nextState = FAULT;
        default: begin
          nextState = OFF;
          nextCnt   = '0;
        end
      endcase

      if (doRetry) begin
        if (retryCnt < RETRY_LIM) begin
          nextRetry = retryCnt + 3'd1;
          nextState = STARTUP;
          nextCnt   = START_LOAD;
        end else begin
          nextState = FAULT;
          nextCnt   = '0;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they switch on the entering edge.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state        <= OFF;
      cycleCnt     <= '0;
      retryCnt     <= '0;
      lowSeen      <= 1'b0;
      BG_EN_O      <= 1'b0;
      BG_STARTUP_O <= 1'b0;
      VBIAS_EN_O   <= 1'b0;
      READY_O      <= 1'b0;
      FAULT_O      <= 1'b0;
      CH_EN_O      <= '0;
      TRIM_BIAS_O  <= 4'b1000;
      TRIM_CURV_O  <= 5'b10000;
      TRIM_VBG_O   <= 5'b10000;
    end else begin
      state        <= nextState;
      cycleCnt     <= nextCnt;
      retryCnt     <= nextRetry;
      lowSeen      <= nextLow;
      BG_EN_O      <= (nextState == STARTUP) || (nextState == SETTLE) || (nextState == READY);
      BG_STARTUP_O <= (nextState == STARTUP);
      READY_O      <= (nextState == READY);
      FAULT_O      <= (nextState == FAULT);
      VBIAS_EN_O   <= (nextState == READY) && EN_VBIAS_I;
      CH_EN_O      <= (nextState == READY) ? CH_EN_I : '0;
      if (TRIM_LD_I && (state != FAULT)) begin
        TRIM_BIAS_O <= TRIM_BIAS_I;
        TRIM_CURV_O <= TRIM_CURV_I;
        TRIM_VBG_O  <= TRIM_VBG_I;
      end
    end
  end

  assign STATE_O = state;

endmodule

// File: tb/tb_riio_bias_ctrl.sv
// Directed bench for riio_bias_ctrl with default parameters: start-up timing,
// retry/fault behaviour, trim loads, READY glitch filtering and async reset.
module tb_riio_bias_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic        en, enVbias, trimLd, bgValidN;
  logic [15:0] chEnI;
  logic [3:0]  trimBiasI;
  logic [4:0]  trimCurvI, trimVbgI;
  logic        bgEn, bgStartup, vbiasEn, readyO, faultO;
  logic [3:0]  trimBiasO;
  logic [4:0]  trimCurvO, trimVbgO;
  logic [15:0] chEnO;
  logic [2:0]  stateO;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int pulseCnt = 0;
  logic prevStartup = 1'b0;

  always #5 clk = ~clk;

  riio_bias_ctrl #(
    .N_CH(16), .STARTUP_CYC(8), .SETTLE_CYC(64), .MAX_RETRY(3)
  ) dut (
    .CLK_I(clk), .RST_N_I(rstN), .EN_I(en), .EN_VBIAS_I(enVbias),
    .CH_EN_I(chEnI), .TRIM_LD_I(trimLd), .TRIM_BIAS_I(trimBiasI),
    .TRIM_CURV_I(trimCurvI), .TRIM_VBG_I(trimVbgI), .BG_VALID_N_I(bgValidN),
    .BG_EN_O(bgEn), .BG_STARTUP_O(bgStartup), .VBIAS_EN_O(vbiasEn),
    .TRIM_BIAS_O(trimBiasO), .TRIM_CURV_O(trimCurvO), .TRIM_VBG_O(trimVbgO),
    .CH_EN_O(chEnO), .READY_O(readyO), .FAULT_O(faultO), .STATE_O(stateO)
  );

  // Counts rising edges of the startup kick.
  always @(negedge clk) begin
    if (bgStartup === 1'b1 && prevStartup !== 1'b1) pulseCnt++;
    prevStartup = bgStartup;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int k;
    int p0;
    rstN = 1'b0; en = 1'b0; enVbias = 1'b0; trimLd = 1'b0; bgValidN = 1'b1;
    chEnI = 16'hA5C3; trimBiasI = '0; trimCurvI = '0; trimVbgI = '0;
    step(3);
    chk("rstState", stateO, 0);
    chk("rstBgEn", bgEn, 0);
    chk("rstReady", readyO, 0);
    chk("rstChEn", chEnO, 0);
    chk("rstTrimBias", trimBiasO, 4'h8);
    chk("rstTrimCurv", trimCurvO, 5'h10);
    chk("rstTrimVbg", trimVbgO, 5'h10);
    rstN = 1'b1;
    step(2);
    chk("offIdle", stateO, 0);

    // Normal start-up
    en = 1'b1;
    step(1);
    chk("startState", stateO, 1);
    chk("startKick", bgStartup, 1);
    chk("startBgEn", bgEn, 1);
    n = 1;
    while (bgStartup === 1'b1 && n < 40) begin
      step(1);
      if (bgStartup === 1'b1) n++;
    end
    chk("startupLen", n, 8);
    chk("settleState", stateO, 2);
    chk("settleBgEn", bgEn, 1);
    step(10);
    bgValidN = 1'b0;
    k = 0;
    while (readyO !== 1'b1 && k < 20) begin step(1); k++; end
    chk("readyLatency", k, 3);
    chk("readyState", stateO, 3);
    chk("readyChEn", chEnO, 16'hA5C3);
    chk("readyVbiasOff", vbiasEn, 0);
    chEnI = 16'h00FF; enVbias = 1'b1;
    step(1);
    chk("chEnUpdate", chEnO, 16'h00FF);
    chk("vbiasOn", vbiasEn, 1);

    // Trim load while READY
    trimBiasI = 4'hF; trimCurvI = 5'h03; trimVbgI = 5'h1A; trimLd = 1'b1;
    step(1);
    trimLd = 1'b0;
    chk("trimBias", trimBiasO, 4'hF);
    chk("trimCurv", trimCurvO, 5'h03);
    chk("trimVbg", trimVbgO, 5'h1A);
    chk("trimSettle", stateO, 2);
    chk("trimReadyDrop", readyO, 0);
    chk("trimChEnOff", chEnO, 0);
    step(1);
    chk("trimBackReady", stateO, 3);
    chk("trimReadyAgain", readyO, 1);

    // Single-cycle valid glitch is filtered
    bgValidN = 1'b1;
    step(1);
    bgValidN = 1'b0;
    step(5);
    chk("glitchReady", readyO, 1);
    chk("glitchState", stateO, 3);

    // Two-cycle drop triggers a retry; then hold invalid until fault
    bgValidN = 1'b1;
    step(2);
    bgValidN = 1'b0;
    step(2);
    chk("dropRetryState", stateO, 1);
    chk("dropReadyOff", readyO, 0);
    p0 = pulseCnt;
    bgValidN = 1'b1;
    k = 0;
    while (faultO !== 1'b1 && k < 1000) begin step(1); k++; end
    chk("retryKeptPulses", pulseCnt - p0, 3);
    chk("faultState", stateO, 4);
    chk("faultBgEn", bgEn, 0);
    chk("faultKick", bgStartup, 0);
    chk("faultVbias", vbiasEn, 0);
    trimBiasI = 4'h3; trimCurvI = 5'h07; trimVbgI = 5'h07; trimLd = 1'b1;
    step(1);
    trimLd = 1'b0;
    chk("faultNoTrim", {trimBiasO, trimCurvO, trimVbgO}, {4'hF, 5'h03, 5'h1A});
    en = 1'b0;
    step(1);
    chk("faultExit", stateO, 0);
    chk("faultClear", faultO, 0);

    // Full failure from a fresh start: 4 attempts, 72 cycles each
    p0 = pulseCnt;
    en = 1'b1;
    k = 0;
    while (faultO !== 1'b1 && k < 2000) begin step(1); k++; end
    chk("faultPulses", pulseCnt - p0, 4);
    chk("faultCycles", k, 289);
    chk("faultState2", stateO, 4);
    en = 1'b0;
    step(1);
    chk("offAfterFault", stateO, 0);

    // Trim load while OFF
    trimBiasI = 4'h5; trimCurvI = 5'h11; trimVbgI = 5'h02; trimLd = 1'b1;
    step(1);
    trimLd = 1'b0;
    chk("offTrim", {trimBiasO, trimCurvO, trimVbgO}, {4'h5, 5'h11, 5'h02});

    // Start with valid already present, then drop EN with a coincident trim load
    bgValidN = 1'b0; chEnI = 16'h1234; enVbias = 1'b1; en = 1'b1;
    k = 0;
    while (readyO !== 1'b1 && k < 100) begin step(1); k++; end
    chk("fastReady", k, 10);
    chk("fastVbias", vbiasEn, 1);
    chk("fastChEn", chEnO, 16'h1234);
    en = 1'b0;
    trimBiasI = 4'hA; trimCurvI = 5'h15; trimVbgI = 5'h0C; trimLd = 1'b1;
    step(1);
    trimLd = 1'b0;
    chk("enDropState", stateO, 0);
    chk("enDropVbias", vbiasEn, 0);
    chk("enDropChEn", chEnO, 0);
    chk("enDropReady", readyO, 0);
    chk("enDropTrim", {trimBiasO, trimCurvO, trimVbgO}, {4'hA, 5'h15, 5'h0C});

    // Asynchronous reset in the middle of SETTLE
    bgValidN = 1'b1; en = 1'b1;
    step(9);
    chk("preRstSettle", stateO, 2);
    step(5);
    #3;
    rstN = 1'b0;
    #1;
    chk("asyncRstState", stateO, 0);
    chk("asyncRstBgEn", bgEn, 0);
    chk("asyncRstChEn", chEnO, 0);
    chk("asyncRstTrim", {trimBiasO, trimCurvO, trimVbgO}, {4'h8, 5'h10, 5'h10});
    step(2);
    #3;
    rstN = 1'b1;
    #1;
    chk("postRstOff", stateO, 0);
    chk("postRstReady", readyO, 0);
    @(posedge clk);
    #1;
    chk("postRstStartup", stateO, 1);
    chk("postRstKick", bgStartup, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
